hsid_mse_ctrl: RTL and testbench
================================

Name: hsid_mse_ctrl

Overview:
Sequencer that drives the two-channel MSE datapath for one pixel against a whole spectral library.
- Streams pixel words and library-vector words from two synchronous read ports into the MSE unit, with start/last/ref sideband.
- Collects the returned per-reference MSE results and reports the best (minimum) match.
- Sits between the pixel/library buffers and the MSE unit, under the top-level CSR/start logic.

Parameters:
WORD_WIDTH, HSID_WORD_WIDTH (32), memory/datapath word; two DATA_WIDTH bands per word
DATA_WIDTH, HSID_DATA_WIDTH (16), band sample width
HSP_BANDS_WIDTH, HSID_HSP_BANDS_WIDTH, width of band count
HSP_LIBRARY_WIDTH, HSID_HSP_LIBRARY_WIDTH, width of library index
DRAIN_CYCLES, 6, cycles waited after the last issued element for MSE pipeline results

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  pulse; begin a sweep (ignored while busy)
hsi_bands  in  HSP_BANDS_WIDTH  bands per vector; sampled on accepted start
library_size  in  HSP_LIBRARY_WIDTH  number of library vectors; sampled on accepted start
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep end
cfg_error  out  1  one-cycle pulse; start rejected, bad config
pix_rd_en  out  1  pixel buffer read strobe
pix_rd_addr  out  HSP_BANDS_WIDTH-1  pixel word index
pix_rd_data  in  WORD_WIDTH  pixel word; valid 1 cycle after pix_rd_en
lib_rd_en  out  1  library read strobe
lib_rd_addr  out  HSP_LIBRARY_WIDTH+HSP_BANDS_WIDTH-1  library word address
lib_rd_data  in  WORD_WIDTH  library word; valid 1 cycle after lib_rd_en
mse_clear  out  1  clear to MSE unit
element_valid, element_start, element_last  out  1 each  to MSE unit
vctr_ref  out  HSP_LIBRARY_WIDTH  to MSE unit
element_a, element_b  out  WORD_WIDTH  to MSE unit (pixel, library)
mse_valid  in  1  result strobe from MSE unit
mse_ref  in  HSP_LIBRARY_WIDTH  result reference
mse_value  in  WORD_WIDTH  result value
best_ref  out  HSP_LIBRARY_WIDTH  index of minimum MSE
best_mse  out  WORD_WIDTH  minimum MSE value
best_valid  out  1  at least one valid result captured in last sweep

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- Config check on start in IDLE:
  - W = hsi_bands>>1.
  - Invalid if hsi_bands is 0 or odd, or library_size is 0: pulse cfg_error next cycle, stay IDLE.
- FSM IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
  - CLEAR: 1 cycle. mse_clear=1; best_valid/best_ref/best_mse cleared; busy=1 from here until DONE.
  - STREAM: one read per cycle on both ports, no bubbles.
    - pix_rd_addr = word_idx.
    - lib_rd_addr = base + word_idx, where base is a running sum incremented by W per vector (no multiplier).
    - word_idx wraps 0..W-1; ref increments on wrap.
    - After issuing word W-1 of ref library_size-1, go to DRAIN.
  - Sideband alignment: element_valid/start/last/vctr_ref are the issue-cycle values registered one cycle, so they align with rd_data.
    - element_start=1 when word_idx==0.
    - element_last=1 when word_idx==W-1.
    - element_a=pix_rd_data and element_b=lib_rd_data, combinational pass-through.
    - W==1: start and last are both high on the same element.
  - DRAIN: counts DRAIN_CYCLES cycles, then DONE.
  - DONE: done=1 for 1 cycle, busy=0, return to IDLE.
- Result capture, active in STREAM and DRAIN:
  - On mse_valid: if !best_valid or mse_value < best_mse, then best_mse<=mse_value, best_ref<=mse_ref, best_valid<=1.
  - Strictly-less rule: on ties the lowest ref wins.
  - Overflowed vectors never assert mse_valid and are never selected; if all overflow, best_valid stays 0.
  - mse_valid in IDLE is ignored.
- start while busy: ignored. start in the same cycle as done: ignored.
- rst_n low mid-sweep: immediate return to IDLE, all outputs 0, no done pulse.

Optional Feature:
HSID_MSE_CTRL_STATS_EN
- Defined: adds output result_cnt [HSP_LIBRARY_WIDTH+1] and of_cnt [HSP_LIBRARY_WIDTH+1].
  - Both cleared in CLEAR.
  - result_cnt increments on each captured mse_valid.
  - of_cnt = library_size - result_cnt, valid when done.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. hsi_bands=4, library_size=3, MSEs (ref0..2) = 50, 20, 35 -> 6 element_valid cycles, element_start at elements 0,2,4, last at 1,3,5; lib_rd_addr 0..5; done; best_ref=1, best_mse=20, best_valid=1.
2. hsi_bands=2, library_size=2 -> element_start and element_last both high on every element; vctr_ref 0 then 1.
3. Ties: MSEs 7, 7, 9 -> best_ref=0, best_mse=7.
4. hsi_bands=3 or library_size=0 with start -> cfg_error pulse, busy stays 0, no read strobes.
5. Assert rst_n=0 during STREAM at ref 1, then release and start with hsi_bands=4, library_size=1 -> clean sweep, best_ref=0, single done pulse.
6. All vectors overflow (no mse_valid) with library_size=2 -> done, best_valid=0; with STATS_EN, result_cnt=0, of_cnt=2.

Source files
------------

// File: rtl/hsid_mse_ctrl_if.sv
// MSE datapath link: element stream from the sequencer, per-reference results back from the MSE unit.
interface hsid_mse_ctrl_if #(
    parameter int WORD_WIDTH        = 32,
    parameter int HSP_LIBRARY_WIDTH = 6
);
    logic                         mse_clear;
    logic                         element_valid;
    logic                         element_start;
    logic                         element_last;
    logic [HSP_LIBRARY_WIDTH-1:0] vctr_ref;
    logic [WORD_WIDTH-1:0]        element_a;
    logic [WORD_WIDTH-1:0]        element_b;
    logic                         mse_valid;
    logic [HSP_LIBRARY_WIDTH-1:0] mse_ref;
    logic [WORD_WIDTH-1:0]        mse_value;

    modport master (
        output mse_clear, element_valid, element_start, element_last, vctr_ref,
               element_a, element_b,
        input  mse_valid, mse_ref, mse_value
    );

    modport slave (
        input  mse_clear, element_valid, element_start, element_last, vctr_ref,
               element_a, element_b,
        output mse_valid, mse_ref, mse_value
    );
endinterface

// File: rtl/hsid_mse_ctrl.sv
// Sweeps one pixel against the spectral library through the MSE unit and keeps the minimum-MSE match.
// Optional HSID_MSE_CTRL_STATS_EN adds result_cnt / of_cnt outputs.
module hsid_mse_ctrl #(
    parameter int WORD_WIDTH        = 32,
    parameter int DATA_WIDTH        = 16,
    parameter int HSP_BANDS_WIDTH   = 8,
    parameter int HSP_LIBRARY_WIDTH = 6,
    parameter int DRAIN_CYCLES      = 6
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [HSP_BANDS_WIDTH-1:0]                hsi_bands,
    input  logic [HSP_LIBRARY_WIDTH-1:0]              library_size,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      cfg_error,
    output logic                                      pix_rd_en,
    output logic [HSP_BANDS_WIDTH-2:0]                pix_rd_addr,
    input  logic [WORD_WIDTH-1:0]                     pix_rd_data,
    output logic                                      lib_rd_en,
    output logic [HSP_LIBRARY_WIDTH+HSP_BANDS_WIDTH-2:0] lib_rd_addr,
    input  logic [WORD_WIDTH-1:0]                     lib_rd_data,
    hsid_mse_ctrl_if.master                           mse,
    output logic [HSP_LIBRARY_WIDTH-1:0]              best_ref,
    output logic [WORD_WIDTH-1:0]                     best_mse,
    output logic                                      best_valid
`ifdef HSID_MSE_CTRL_STATS_EN
    ,
    output logic [HSP_LIBRARY_WIDTH:0]                result_cnt,
    output logic [HSP_LIBRARY_WIDTH:0]                of_cnt
`endif
);
    localparam int WI  = HSP_BANDS_WIDTH - 1;
    localparam int LW  = HSP_LIBRARY_WIDTH;
    localparam int LA  = HSP_LIBRARY_WIDTH + HSP_BANDS_WIDTH - 1;
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned W_SHIFT = $clog2(WORD_WIDTH / DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [WI-1:0]   w_q, word_idx, w_calc;
    logic [LW-1:0]   lib_size_q, ref_idx;
    logic [LA-1:0]   base;
    logic [DCW-1:0]  drain_cnt;
    logic            cfg_bad, word_last, ref_last, drain_end, collecting, res_strobe, take;

    assign w_calc     = WI'(hsi_bands >> W_SHIFT);
    assign cfg_bad    = (hsi_bands == '0) || hsi_bands[0] || (library_size == '0);
    assign word_last  = (word_idx == w_q - 1'b1);
    assign ref_last   = (ref_idx == lib_size_q - 1'b1);
    assign drain_end  = (drain_cnt == DCW'(DRAIN_CYCLES - 1));
    assign collecting = (state == S_STREAM) || (state == S_DRAIN);
    assign res_strobe = collecting && mse.mse_valid;
    // Strict less-than: on equal MSE the earlier (lower) reference is kept.
    assign take       = res_strobe && (!best_valid || (mse.mse_value < best_mse));

    assign pix_rd_addr   = word_idx;
    assign lib_rd_addr   = base + LA'(word_idx);
    assign mse.element_a = pix_rd_data;
    assign mse.element_b = lib_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start && !cfg_bad) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_STREAM;
            S_STREAM: if (word_last && ref_last) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_end) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        mse.mse_clear = 1'b0;
        pix_rd_en     = 1'b0;
        lib_rd_en     = 1'b0;
        unique case (state)
            S_CLEAR:  begin busy = 1'b1; mse.mse_clear = 1'b1; end
            S_STREAM: begin busy = 1'b1; pix_rd_en = 1'b1; lib_rd_en = 1'b1; end
            S_DRAIN:  busy = 1'b1;
            S_DONE:   done = 1'b1;
            default:  ;
        endcase
    end

`ifdef HSID_MSE_CTRL_STATS_EN
    logic [LW:0] result_cnt_nxt;
    assign result_cnt_nxt = result_cnt + {{LW{1'b0}}, res_strobe};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_cnt <= '0;
            of_cnt     <= '0;
        end else if (state == S_CLEAR) begin
            result_cnt <= '0;
            of_cnt     <= '0;
        end else begin
            result_cnt <= result_cnt_nxt;
            if (state == S_DRAIN && drain_end)
                of_cnt <= {1'b0, lib_size_q} - result_cnt_nxt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_error         <= 1'b0;
            w_q               <= '0;
            lib_size_q        <= '0;
            word_idx          <= '0;
            ref_idx           <= '0;
            base              <= '0;
            drain_cnt         <= '0;
            mse.element_valid <= 1'b0;
            mse.element_start <= 1'b0;
            mse.element_last  <= 1'b0;
            mse.vctr_ref      <= '0;
            best_ref          <= '0;
            best_mse          <= '0;
            best_valid        <= 1'b0;
        end else begin
            cfg_error <= 1'b0;
            unique case (state)
                S_IDLE: if (start) begin
                    if (cfg_bad) begin
                        cfg_error <= 1'b1;
                    end else begin
                        w_q        <= w_calc;
                        lib_size_q <= library_size;
                    end
                end
                S_CLEAR: begin
                    word_idx   <= '0;
                    ref_idx    <= '0;
                    base       <= '0;
                    drain_cnt  <= '0;
                    best_ref   <= '0;
                    best_mse   <= '0;
                    best_valid <= 1'b0;
                end
                // Library base advances by W per vector, so no multiply is needed for the address.
                S_STREAM: if (word_last) begin
                    word_idx <= '0;
                    ref_idx  <= ref_idx + 1'b1;
                    base     <= base + LA'(w_q);
                end else begin
                    word_idx <= word_idx + 1'b1;
                end
                S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
                default: ;
            endcase

            mse.element_valid <= (state == S_STREAM);
            mse.element_start <= (state == S_STREAM) && (word_idx == '0);
            mse.element_last  <= (state == S_STREAM) && word_last;
            mse.vctr_ref      <= (state == S_STREAM) ? ref_idx : '0;

            if (take) begin
                best_mse   <= mse.mse_value;
                best_ref   <= mse.mse_ref;
                best_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hsid_mse_ctrl.sv
// Directed bench for hsid_mse_ctrl with buffer models and a two-stage MSE unit stand-in.
module tb_hsid_mse_ctrl;
    localparam int WW = 32;
    localparam int BW = 8;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [BW-1:0] hsi_bands = '0;
    logic [LW-1:0] library_size = '0;
    logic          busy, done, cfg_error, pix_rd_en, lib_rd_en;
    logic [BW-2:0] pix_rd_addr;
    logic [LW+BW-2:0] lib_rd_addr;
    logic [WW-1:0] pix_rd_data = '0, lib_rd_data = '0;
    logic [LW-1:0] best_ref;
    logic [WW-1:0] best_mse;
    logic          best_valid;
`ifdef HSID_MSE_CTRL_STATS_EN
    logic [LW:0]   result_cnt, of_cnt;
`endif

    hsid_mse_ctrl_if #(.WORD_WIDTH(WW), .HSP_LIBRARY_WIDTH(LW)) mse_if ();

    hsid_mse_ctrl #(
        .WORD_WIDTH(WW), .DATA_WIDTH(16), .HSP_BANDS_WIDTH(BW),
        .HSP_LIBRARY_WIDTH(LW), .DRAIN_CYCLES(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hsi_bands(hsi_bands),
        .library_size(library_size), .busy(busy), .done(done), .cfg_error(cfg_error),
        .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
        .lib_rd_en(lib_rd_en), .lib_rd_addr(lib_rd_addr), .lib_rd_data(lib_rd_data),
        .mse(mse_if.master), .best_ref(best_ref), .best_mse(best_mse), .best_valid(best_valid)
`ifdef HSID_MSE_CTRL_STATS_EN
        , .result_cnt(result_cnt), .of_cnt(of_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Buffers: one-cycle read latency; contents are a simple function of the address.
    always @(posedge clk) begin
        if (pix_rd_en) pix_rd_data <= 32'h1000 + 32'(pix_rd_addr);
        if (lib_rd_en) lib_rd_data <= 32'h2000 + 32'(lib_rd_addr);
    end

    // MSE stand-in: result for a vector two cycles after its last element, unless flagged as overflowed.
    logic [WW-1:0] mse_tbl [64];
    logic [63:0]   of_mask = '0;
    logic          p1_v = 1'b0, p2_v = 1'b0;
    logic [LW-1:0] p1_ref = '0, p2_ref = '0;
    always @(posedge clk) begin
        if (!rst_n) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
        end else begin
            p1_v   <= mse_if.element_valid && mse_if.element_last;
            p1_ref <= mse_if.vctr_ref;
            p2_v   <= p1_v;
            p2_ref <= p1_ref;
        end
    end
    assign mse_if.mse_valid = p2_v && !of_mask[p2_ref];
    assign mse_if.mse_ref   = p2_ref;
    assign mse_if.mse_value = mse_tbl[p2_ref];

    int n_cmp = 0, n_err = 0;
    int done_cnt, cfg_cnt, busy_cnt, n_elem, n_rd, n_pix;
    logic [63:0]   start_mask, last_mask;
    logic [LW-1:0] ref_log  [64];
    logic [WW-1:0] a_log    [64];
    logic [WW-1:0] b_log    [64];
    logic [LW+BW-2:0] addr_log [64];

    always @(negedge clk) begin
        if (mse_if.element_valid && n_elem < 64) begin
            start_mask[n_elem] = mse_if.element_start;
            last_mask[n_elem]  = mse_if.element_last;
            ref_log[n_elem]    = mse_if.vctr_ref;
            a_log[n_elem]      = mse_if.element_a;
            b_log[n_elem]      = mse_if.element_b;
            n_elem++;
        end
        if (lib_rd_en && n_rd < 64) begin
            addr_log[n_rd] = lib_rd_addr;
            n_rd++;
        end
        if (pix_rd_en) n_pix++;
        if (done)      done_cnt++;
        if (cfg_error) cfg_cnt++;
        if (busy)      busy_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        done_cnt = 0; cfg_cnt = 0; busy_cnt = 0; n_elem = 0; n_rd = 0; n_pix = 0;
        start_mask = '0; last_mask = '0;
    endtask

    task automatic kick(input int bands, input int lib);
        clear_logs();
        hsi_bands    = BW'(bands);
        library_size = LW'(lib);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 400 && done_cnt == 0; i++) tick();
        if (done_cnt == 0) check({tag, "_timeout"}, 0, 1);
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mse_tbl[i] = 32'd1000;
        clear_logs();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_best_valid", best_valid, 0);
        check("rst_pix_rd_en", pix_rd_en, 0);
        check("rst_elem_valid", mse_if.element_valid, 0);
        rst_n = 1'b1;
        tick();

        // 1: four bands, three vectors, minimum in the middle
        mse_tbl[0] = 50; mse_tbl[1] = 20; mse_tbl[2] = 35;
        kick(4, 3);
        check("t1_busy_clear", busy, 1);
        check("t1_mse_clear", mse_if.mse_clear, 1);
        wait_done("t1");
        check("t1_done_cnt", done_cnt, 1);
        check("t1_n_elem", n_elem, 6);
        check("t1_start_mask", start_mask, 64'd21);
        check("t1_last_mask", last_mask, 64'd42);
        check("t1_n_rd", n_rd, 6);
        check("t1_n_pix", n_pix, 6);
        for (int k = 0; k < 6; k++) begin
            check("t1_lib_addr", addr_log[k], k);
            check("t1_elem_a", a_log[k], 32'h1000 + (k % 2));
            check("t1_elem_b", b_log[k], 32'h2000 + k);
            check("t1_vctr_ref", ref_log[k], k / 2);
        end
        check("t1_best_ref", best_ref, 1);
        check("t1_best_mse", best_mse, 20);
        check("t1_best_valid", best_valid, 1);
        check("t1_busy_after", busy, 0);
`ifdef HSID_MSE_CTRL_STATS_EN
        check("t1_result_cnt", result_cnt, 3);
        check("t1_of_cnt", of_cnt, 0);
`endif

        // 2: one word per vector, start and last coincide
        mse_tbl[0] = 5; mse_tbl[1] = 4;
        kick(2, 2);
        wait_done("t2");
        check("t2_n_elem", n_elem, 2);
        check("t2_start_mask", start_mask, 64'd3);
        check("t2_last_mask", last_mask, 64'd3);
        check("t2_ref0", ref_log[0], 0);
        check("t2_ref1", ref_log[1], 1);
        check("t2_best_ref", best_ref, 1);
        check("t2_best_mse", best_mse, 4);

        // 3: tie goes to the lower reference
        mse_tbl[0] = 7; mse_tbl[1] = 7; mse_tbl[2] = 9;
        kick(2, 3);
        wait_done("t3");
        check("t3_best_ref", best_ref, 0);
        check("t3_best_mse", best_mse, 7);
        check("t3_best_valid", best_valid, 1);

        // 4: rejected configurations
        kick(3, 2);
        for (int i = 0; i < 5; i++) tick();
        check("t4a_cfg_cnt", cfg_cnt, 1);
        check("t4a_busy_cnt", busy_cnt, 0);
        check("t4a_n_rd", n_rd + n_pix, 0);
        kick(4, 0);
        for (int i = 0; i < 5; i++) tick();
        check("t4b_cfg_cnt", cfg_cnt, 1);
        check("t4b_busy_cnt", busy_cnt, 0);
        check("t4b_n_rd", n_rd + n_pix, 0);
        check("t4b_done_cnt", done_cnt, 0);

        // 5: reset while streaming vector 1, then a clean single-vector sweep
        mse_tbl[0] = 60; mse_tbl[1] = 10; mse_tbl[2] = 80;
        kick(4, 3);
        begin
            int i;
            for (i = 0; i < 50 && !(lib_rd_en && lib_rd_addr == 2); i++) tick();
            check("t5_reach_ref1", lib_rd_en && lib_rd_addr == 2, 1);
        end
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rd_en", lib_rd_en, 0);
        check("t5_rst_elem_valid", mse_if.element_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t5_no_done", done_cnt, 0);
        check("t5_best_valid_rst", best_valid, 0);
        mse_tbl[0] = 33;
        kick(4, 1);
        wait_done("t5");
        check("t5_done_cnt", done_cnt, 1);
        check("t5_best_ref", best_ref, 0);
        check("t5_best_mse", best_mse, 33);
        check("t5_best_valid", best_valid, 1);

        // 6: every vector overflows
        of_mask = 64'h3;
        kick(4, 2);
        wait_done("t6");
        check("t6_done_cnt", done_cnt, 1);
        check("t6_best_valid", best_valid, 0);
        check("t6_best_mse", best_mse, 0);
`ifdef HSID_MSE_CTRL_STATS_EN
        check("t6_result_cnt", result_cnt, 0);
        check("t6_of_cnt", of_cnt, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
